// File: rtl/fifo_lane_dispatch_1w2r.sv
// One-write / two-lane-read FIFO: the oldest two entries are presented in parallel, and the consumer pops 0, 1 or 2 per cycle.
// Optional sticky protocol-error flag enabled by defining FIFO_LANE_DISPATCH_1W2R_ERR_EN.
module fifo_lane_dispatch_1w2r #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [WIDTH-1:0]         data_out0,
  output logic [WIDTH-1:0]         data_out1,
  output logic                     valid_out0,
  output logic                     valid_out1,
  input  logic [1:0]               pop_num,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    rd_ptr_nx_c;
  logic             wr_en_c;
  logic [1:0]       pop_req_c;
  logic [1:0]       eff_pop_c;

  // Accept, clamp the pop request to what is stored, and advance the pointers.
  always_comb begin
    wr_en_c   = valid_in && (count_q < CW'(DEPTH));
    pop_req_c = (pop_num == 2'd3) ? 2'd2 : pop_num;
    eff_pop_c = (CW'(pop_req_c) > count_q) ? count_q[1:0] : pop_req_c;
    wr_ptr_d  = wr_en_c ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = rd_ptr_q + AW'(eff_pop_c);
    count_d   = count_q + CW'(wr_en_c) - CW'(eff_pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset; the cleared count hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign rd_ptr_nx_c = rd_ptr_q + AW'(1);
  assign ready_in    = (count_q < CW'(DEPTH));
  assign valid_out0  = (count_q >= CW'(1));
  assign valid_out1  = (count_q >= CW'(2));
  assign data_out0   = valid_out0 ? mem_q[rd_ptr_q]    : '0;
  assign data_out1   = valid_out1 ? mem_q[rd_ptr_nx_c] : '0;
  assign count       = count_q;

`ifdef FIFO_LANE_DISPATCH_1W2R_ERR_EN
  logic err_q, err_d;

  // Sticky: over-pop or the reserved pop code latches until reset.
  always_comb begin
    err_d = err_q | (pop_num == 2'd3) | (CW'(pop_num) > count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lane_dispatch_1w2r.sv
// Directed bench for fifo_lane_dispatch_1w2r (WIDTH=32, DEPTH=8).
module tb_fifo_lane_dispatch_1w2r;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef FIFO_LANE_DISPATCH_1W2R_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out0;
  logic             valid_out1;
  logic [1:0]       pop_num;
  logic [CW-1:0]    count;
  logic             err;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q [$];

  fifo_lane_dispatch_1w2r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out0(data_out0), .data_out1(data_out1), .valid_out0(valid_out0),
    .valid_out1(valid_out1), .pop_num(pop_num), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; data_in = '0; valid_in = 1'b0; pop_num = 2'd0;
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(ready_in), 64'd1);
    check("rst_v0", 64'(valid_out0), 64'd0);
    check("rst_v1", 64'(valid_out1), 64'd0);
    check("rst_d0", 64'(data_out0), 64'd0);
    check("rst_d1", 64'(data_out1), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // First cycle after reset release: write accepted, not bypassed.
    rst = 1'b0;
    valid_in = 1'b1; data_in = 32'hA;
    #1;
    check("nobypass_v0", 64'(valid_out0), 64'd0);
    check("nobypass_d0", 64'(data_out0), 64'd0);
    tick();
    check("first_wr_count", 64'(count), 64'd1);
    check("first_wr_d0", 64'(data_out0), 64'hA);
    data_in = 32'hB; tick();
    data_in = 32'hC; tick();
    valid_in = 1'b0;
    check("abc_count", 64'(count), 64'd3);
    check("abc_d0", 64'(data_out0), 64'hA);
    check("abc_d1", 64'(data_out1), 64'hB);
    check("abc_v0", 64'(valid_out0), 64'd1);
    check("abc_v1", 64'(valid_out1), 64'd1);

    pop_num = 2'd2; tick();
    check("pop2_count", 64'(count), 64'd1);
    check("pop2_d0", 64'(data_out0), 64'hC);
    check("pop2_v1", 64'(valid_out1), 64'd0);
    check("pop2_d1", 64'(data_out1), 64'd0);
    pop_num = 2'd1; tick();
    pop_num = 2'd0;
    check("empty_count", 64'(count), 64'd0);

    // Fill to full, then write-while-full with a pop.
    valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 32'h10 + 32'(i); tick();
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(ready_in), 64'd0);
    data_in = 32'hFF; pop_num = 2'd1; tick();
    valid_in = 1'b0; pop_num = 2'd0;
    check("fullpop_count", 64'(count), 64'd7);
    check("fullpop_ready", 64'(ready_in), 64'd1);
    for (int i = 1; i < 8; i++) begin
      check("drain_d0", 64'(data_out0), 64'(32'h10 + 32'(i)));
      pop_num = 2'd1; tick();
    end
    pop_num = 2'd0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_v0", 64'(valid_out0), 64'd0);

    // Simultaneous write and pop at count=1.
    valid_in = 1'b1; data_in = 32'h4; tick();
    data_in = 32'h5; pop_num = 2'd1; tick();
    valid_in = 1'b0; pop_num = 2'd0;
    check("wrpop_count", 64'(count), 64'd1);
    check("wrpop_d0", 64'(data_out0), 64'h5);
    pop_num = 2'd1; tick();
    pop_num = 2'd0;

    // Pointer wrap: two writes then a double pop, 20 entries total.
    for (int r = 0; r < 10; r++) begin
      valid_in = 1'b1;
      for (int k = 0; k < 2; k++) begin
        data_in = 32'h100 + 32'(2 * r + k);
        exp_q.push_back(data_in);
        tick();
      end
      valid_in = 1'b0;
      check("wrap_count", 64'(count), 64'd2);
      check("wrap_d0", 64'(data_out0), 64'(exp_q.pop_front()));
      check("wrap_d1", 64'(data_out1), 64'(exp_q.pop_front()));
      pop_num = 2'd2; tick();
      pop_num = 2'd0;
    end
    check("wrap_end_count", 64'(count), 64'd0);

    // pop_num=3 behaves as a pop of two.
    valid_in = 1'b1;
    data_in = 32'h21; tick();
    data_in = 32'h22; tick();
    data_in = 32'h23; tick();
    valid_in = 1'b0;
    pop_num = 2'd3; tick();
    pop_num = 2'd0;
    check("pop3_count", 64'(count), 64'd1);
    check("pop3_d0", 64'(data_out0), 64'h23);

    // Over-pop at count=1 clamps and, when enabled, latches err.
    pop_num = 2'd2; tick();
    pop_num = 2'd0;
    check("overpop_count", 64'(count), 64'd0);
    check("overpop_err", 64'(err), 64'(ERR_EXP));
    tick(); tick();
    check("err_sticky", 64'(err), 64'(ERR_EXP));

    // Reset mid-operation discards entries and clears err.
    valid_in = 1'b1; data_in = 32'h77; tick();
    valid_in = 1'b0;
    rst = 1'b1; #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_v0", 64'(valid_out0), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    tick();
    rst = 1'b0; tick();
    check("postrst_count", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_lane_dispatch_1w2r.md
FIFO_LANE_DISPATCH_1W2R -- requirements
Module: fifo_lane_dispatch_1w2r

Interface
REQ-001 Parameter WIDTH, default 32: data bits per entry and per lane.
REQ-002 Parameter DEPTH, default 8: storage entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  WIDTH  write data.
REQ-006 valid_in  input  1  write request.
REQ-007 ready_in  output  1  space available; a write is accepted when valid_in and ready_in are both high.
REQ-008 data_out0  output  WIDTH  head entry (oldest).
REQ-009 data_out1  output  WIDTH  entry after the head.
REQ-010 valid_out0  output  1  data_out0 holds a stored entry.
REQ-011 valid_out1  output  1  data_out1 holds a stored entry.
REQ-012 pop_num  input  2  number of lane entries the consumer takes this cycle (0, 1 or 2).
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-015 Storage SHALL be a DEPTH-entry circular buffer addressed by read and write pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-016 ready_in SHALL equal (count < DEPTH); a same-cycle pop SHALL NOT raise ready_in when full.
REQ-017 An accepted write SHALL store data_in at the write pointer and advance the pointer by 1; valid_in while ready_in is low SHALL be ignored.
REQ-018 valid_out0 SHALL equal (count >= 1) and valid_out1 SHALL equal (count >= 2), combinationally from registered state.
REQ-019 data_out0 SHALL be mem[rd_ptr] and data_out1 SHALL be mem[rd_ptr+1 mod DEPTH]; each SHALL be forced to all-zero while its valid is low.
REQ-020 Effective pop SHALL be min(pop_num, count), with pop_num=3 treated as 2; the read pointer SHALL advance by the effective pop, modulo DEPTH.
REQ-021 Lanes SHALL stay packed: lane 1 is never valid unless lane 0 is valid, and a single pop always takes lane 0.
REQ-022 Next count SHALL be count + accepted_write - effective_pop, applied in the same cycle; simultaneous write and pop SHALL both take effect.
REQ-023 A write SHALL become visible on the output lanes no earlier than the cycle after acceptance (no write-to-read bypass).
REQ-024 Entry ordering SHALL be strict FIFO: entries emerge on lane 0 then lane 1 in write order.

Reset
REQ-025 While rst is high: read pointer, write pointer and count SHALL be 0; ready_in=1, valid_out0=0, valid_out1=0, data_out0=0, data_out1=0, err=0.
REQ-026 Storage contents SHALL NOT be reset; a reset mid-operation SHALL discard all entries.
REQ-027 A write presented in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro FIFO_LANE_DISPATCH_1W2R_ERR_EN: when defined, err SHALL set and stay high until reset on any cycle where pop_num > count or pop_num == 3.
REQ-029 Without FIFO_LANE_DISPATCH_1W2R_ERR_EN, err SHALL be tied to 0 and no error logic SHALL be built; clamping per REQ-020 applies in both builds.

Verification
REQ-030 Reset, then write 0xA,0xB,0xC on consecutive cycles with pop_num=0 -> count=3, data_out0=0xA, data_out1=0xB, both valids high.
REQ-031 Then pop_num=2 for one cycle -> count=1, data_out0=0xC, valid_out1=0, data_out1=0.
REQ-032 DEPTH=8: write 8 entries -> ready_in=0; further write 0xFF plus pop_num=1 -> count=7, 0xFF not stored, ready_in=1 the next cycle.
REQ-033 Count=1 with write 0x5 and pop_num=1 in the same cycle -> count=1, data_out0=0x5 the next cycle.
REQ-034 Write and pop across pointer wrap (20 entries, pop_num=2 alternating with two writes) -> output sequence equals write sequence, no loss.
REQ-035 With ERR_EN, count=1 and pop_num=2 -> count=0 and err=1, held until rst; without ERR_EN, err remains 0.
